// File: rtl/ram_loader_if.sv
// Host-stream, RAM write-port and status signals of the program-RAM loader.
// master is the loader side; slave is the host/RAM/CPU side.
interface ram_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_sel;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              done;
    logic              fail;
    logic [DATA_W-1:0] checksum;

    modport master (
        input  start, load_len, in_data, in_valid, ram_rdata,
        output in_ready, ram_addr, ram_wdata, ram_sel, busy, done, fail, checksum
    );

    modport slave (
        output start, load_len, in_data, in_valid, ram_rdata,
        input  in_ready, ram_addr, ram_wdata, ram_sel, busy, done, fail, checksum
    );
endinterface

// File: rtl/ram_loader.sv
// Streams host bytes into the program RAM from address 0, then reads them back
// and compares a mod-2^DATA_W checksum. All outputs are flops decoded from next state.
module ram_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic         clk,
    input logic         rst,
    ram_loader_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, CHECK, DONE, FAIL} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  len, len_n, wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n, len_req;
    logic [DATA_W-1:0] cks, cks_n, rd_sum, rd_sum_n, wdata, wdata_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              sel, sel_n, rdy, rdy_n, busy_q, busy_n;
    logic              done_q, done_n, fail_q, fail_n;

    assign len_req = (bus.load_len == '0 || bus.load_len > DEPTH) ? DEPTH : bus.load_len;

    always_comb begin
        state_n  = state;
        len_n    = len;
        wr_cnt_n = wr_cnt;
        rd_cnt_n = rd_cnt;
        cks_n    = cks;
        rd_sum_n = rd_sum;
        wdata_n  = wdata;
        case (state)
            IDLE, DONE, FAIL: begin
                if (bus.start) begin
                    state_n  = LOAD;
                    len_n    = len_req;
                    wr_cnt_n = '0;
                    rd_cnt_n = '0;
                    cks_n    = '0;
                    rd_sum_n = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid && rdy) begin
                    wdata_n = bus.in_data;
                    cks_n   = cks + bus.in_data;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (wr_cnt == len - ONE) begin
                    state_n  = VERIFY;
                    rd_cnt_n = '0;
                end else begin
                    wr_cnt_n = wr_cnt + ONE;
                    state_n  = LOAD;
                end
            end
            VERIFY: begin
                rd_sum_n = rd_sum + bus.ram_rdata;
                rd_cnt_n = rd_cnt + ONE;
                if (rd_cnt == len - ONE) state_n = CHECK;
            end
            CHECK:   state_n = (rd_sum == cks) ? DONE : FAIL;
            default: state_n = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so ram_sel is glitch-free.
    always_comb begin
        sel_n  = (state_n != WRITE);
        addr_n = '0;
        if (state_n == WRITE)  addr_n = wr_cnt_n[ADDR_W-1:0];
        if (state_n == VERIFY) addr_n = rd_cnt_n[ADDR_W-1:0];
        rdy_n  = (state_n == LOAD);
        busy_n = (state_n == LOAD) || (state_n == WRITE) ||
                 (state_n == VERIFY) || (state_n == CHECK);
        done_n = (state_n == DONE);
        fail_n = (state_n == FAIL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            len    <= '0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            cks    <= '0;
            rd_sum <= '0;
            wdata  <= '0;
            addr   <= '0;
            sel    <= 1'b1;
            rdy    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state  <= state_n;
            len    <= len_n;
            wr_cnt <= wr_cnt_n;
            rd_cnt <= rd_cnt_n;
            cks    <= cks_n;
            rd_sum <= rd_sum_n;
            wdata  <= wdata_n;
            addr   <= addr_n;
            sel    <= sel_n;
            rdy    <= rdy_n;
            busy_q <= busy_n;
            done_q <= done_n;
            fail_q <= fail_n;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.ram_addr  = addr;
    assign bus.ram_wdata = wdata;
    assign bus.ram_sel   = sel;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.checksum  = cks;
endmodule
